// File: rtl/skid_reg_slice_pkg.sv
// Shared types and sizing for the two-entry valid/ready skid slice.
package skid_reg_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

    function automatic logic [CNT_W-1:0] occupancy(input skid_state_e s);
        case (s)
            ONE:     occupancy = CNT_W'(1);
            FULL:    occupancy = CNT_W'(2);
            default: occupancy = '0;
        endcase
    endfunction

endpackage

// File: rtl/dff_prims.sv
// Common flop primitives: reset-to-zero, reset-to-ones, reset-to-constant, enabled.
module dffr #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) q <= '0;
        else          q <= d;
endmodule

module dffrh #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) q <= '1;
        else          q <= d;
endmodule

module dffrc #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) q <= RESET_VAL;
        else          q <= d;
endmodule

module dffer #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) q <= '0;
        else if (en)  q <= d;
endmodule

// File: rtl/skid_reg_slice_ctrl.sv
// Next-state, data-enable and registered-output decode for the skid slice.
module skid_reg_slice_ctrl
    import skid_reg_slice_pkg::*;
(
    input  skid_state_e      state,
    input  logic             flush_i,
    input  logic             s_valid_i,
    input  logic             m_ready_i,
    input  logic             s_ready,
    input  logic             m_valid,
    output skid_state_e      state_nxt,
    output logic             main_en,
    output logic             main_from_skid,
    output logic             skid_en,
    output logic             s_ready_nxt,
    output logic             m_valid_nxt,
    output logic [CNT_W-1:0] cnt_nxt
);
    logic push, pop;

    assign push = s_valid_i & s_ready;
    assign pop  = m_valid & m_ready_i;

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (push) state_nxt = ONE;
                ONE: begin
                    if (push && !pop)      state_nxt = FULL;
                    else if (!push && pop) state_nxt = EMPTY;
                end
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // A flushed cycle loads nothing; the dropped beat must not reach main or skid.
    always_comb begin
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (!flush_i) begin
            case (state)
                EMPTY: main_en = push;
                ONE: begin
                    main_en = push & pop;
                    skid_en = push & ~pop;
                end
                FULL: begin
                    main_en        = pop;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
        s_ready_nxt = (state_nxt != FULL);
        m_valid_nxt = (state_nxt != EMPTY);
        cnt_nxt     = occupancy(state_nxt);
    end

endmodule

// File: rtl/skid_reg_slice.sv
// Two-entry valid/ready register slice; every output comes straight from a flop.
// Define SKID_REG_SLICE_ASSERT_EN to compile in the protocol assertions.
module skid_reg_slice
    import skid_reg_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_dat_o,
    output logic [1:0]            cnt_o
);
    logic [1:0]            state_q;
    skid_state_e           state, state_nxt;
    logic                  main_en, main_from_skid, skid_en;
    logic                  s_ready_nxt, m_valid_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [DATA_WIDTH-1:0] skid_q, main_d;

    assign state = skid_state_e'(state_q);

    skid_reg_slice_ctrl u_ctrl (
        .state          (state),
        .flush_i        (flush_i),
        .s_valid_i      (s_valid_i),
        .m_ready_i      (m_ready_i),
        .s_ready        (s_ready_o),
        .m_valid        (m_valid_o),
        .state_nxt      (state_nxt),
        .main_en        (main_en),
        .main_from_skid (main_from_skid),
        .skid_en        (skid_en),
        .s_ready_nxt    (s_ready_nxt),
        .m_valid_nxt    (m_valid_nxt),
        .cnt_nxt        (cnt_nxt)
    );

    dffrc #(.W(2), .RESET_VAL(EMPTY)) u_state (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d(state_nxt), .q(state_q));

    dffrh #(.W(1)) u_s_ready (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d(s_ready_nxt), .q(s_ready_o));

    dffr #(.W(1)) u_m_valid (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d(m_valid_nxt), .q(m_valid_o));

    dffr #(.W(2)) u_cnt (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d(cnt_nxt), .q(cnt_o));

    // Main refills from skid when draining FULL, else takes the producer beat.
    assign main_d = main_from_skid ? skid_q : s_dat_i;

    dffer #(.W(DATA_WIDTH)) u_main (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en(main_en), .d(main_d), .q(m_dat_o));

    dffer #(.W(DATA_WIDTH)) u_skid (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en(skid_en), .d(s_dat_i), .q(skid_q));

`ifdef SKID_REG_SLICE_ASSERT_EN
    a_s_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        s_valid_i && !s_ready_o |=> s_valid_i && $stable(s_dat_i));

    a_m_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        m_valid_o && !m_ready_i && !flush_i |=> m_valid_o && $stable(m_dat_o));

    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        cnt_o != 2'd3);

    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !$isunknown({s_valid_i, m_ready_i, flush_i}));
`endif

endmodule

// File: tb/tb_skid_reg_slice.sv
// Bench for skid_reg_slice: directed vector table, async reset, random scoreboard run.
module tb_skid_reg_slice;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [31:0] s_dat_i = '0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b0;
    logic [31:0] m_dat_o;
    logic [1:0]  cnt_o;

    skid_reg_slice #(.DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_dat_i(s_dat_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_dat_o(m_dat_o),
        .cnt_o(cnt_o));

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        ev;
        logic        er;
        logic [1:0]  ec;
        logic [31:0] ed;
    } vec_t;

    localparam int NV = 20;
    vec_t        vecs[NV];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] sbq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic fl, input logic sv, input logic [31:0] sd,
                                input logic mr, input logic ev, input logic er,
                                input logic [1:0] ec, input logic [31:0] ed);
        vec_t v;
        v.flush = fl; v.sv = sv; v.sd = sd; v.mr = mr;
        v.ev = ev; v.er = er; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    initial begin
        int   sent, cyc;
        logic pushed;
        logic [31:0] exp_d;

        //             fl sv  data         mr  v  r  cnt  m_dat
        vecs[0]  = mk(0, 1, 32'h11, 1, 1, 1, 1, 32'h11);   // streaming
        vecs[1]  = mk(0, 1, 32'h22, 1, 1, 1, 1, 32'h22);
        vecs[2]  = mk(0, 1, 32'h33, 1, 1, 1, 1, 32'h33);
        vecs[3]  = mk(0, 1, 32'h44, 1, 1, 1, 1, 32'h44);
        vecs[4]  = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        vecs[5]  = mk(0, 1, 32'hA0, 0, 1, 1, 1, 32'hA0);   // backpressure
        vecs[6]  = mk(0, 1, 32'hA1, 0, 1, 0, 2, 32'hA0);
        vecs[7]  = mk(0, 1, 32'hA2, 0, 1, 0, 2, 32'hA0);
        vecs[8]  = mk(0, 1, 32'hA2, 0, 1, 0, 2, 32'hA0);
        vecs[9]  = mk(0, 1, 32'hA2, 1, 1, 1, 1, 32'hA1);
        vecs[10] = mk(0, 1, 32'hA2, 1, 1, 1, 1, 32'hA2);
        vecs[11] = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        vecs[12] = mk(0, 1, 32'h55, 0, 1, 1, 1, 32'h55);   // push+pop in ONE
        vecs[13] = mk(0, 1, 32'h66, 1, 1, 1, 1, 32'h66);
        vecs[14] = mk(0, 0, 32'h0,  0, 1, 1, 1, 32'h66);
        vecs[15] = mk(0, 1, 32'h77, 0, 1, 0, 2, 32'h66);   // fill, then flush
        vecs[16] = mk(1, 1, 32'h88, 0, 0, 1, 0, 32'h0);
        vecs[17] = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        vecs[18] = mk(0, 1, 32'h99, 0, 1, 1, 1, 32'h99);
        vecs[19] = mk(0, 1, 32'hAA, 0, 1, 0, 2, 32'h99);   // FULL for async reset

        #12 rst_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            check("idle_s_ready", 32'(s_ready_o), 32'd1);
            check("idle_m_valid", 32'(m_valid_o), 32'd0);
            check("idle_cnt", 32'(cnt_o), 32'd0);
        end

        for (int i = 0; i < NV; i++) begin
            flush_i = vecs[i].flush; s_valid_i = vecs[i].sv;
            s_dat_i = vecs[i].sd;    m_ready_i = vecs[i].mr;
            @(posedge clk_i); #1;
            check($sformatf("v%0d_m_valid", i), 32'(m_valid_o), 32'(vecs[i].ev));
            check($sformatf("v%0d_s_ready", i), 32'(s_ready_o), 32'(vecs[i].er));
            check($sformatf("v%0d_cnt", i), 32'(cnt_o), 32'(vecs[i].ec));
            if (vecs[i].ev) check($sformatf("v%0d_m_dat", i), m_dat_o, vecs[i].ed);
        end

        // Async reset between edges while FULL
        flush_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_m_valid", 32'(m_valid_o), 32'd0);
        check("arst_s_ready", 32'(s_ready_o), 32'd1);
        check("arst_cnt", 32'(cnt_o), 32'd0);
        check("arst_m_dat", m_dat_o, 32'd0);
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Random producer/consumer run against a FIFO scoreboard
        sent = 0; cyc = 0; pushed = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!s_valid_i || pushed) begin
                s_valid_i = 1'($urandom_range(0, 1));
                s_dat_i   = $urandom;
            end
            m_ready_i = ($urandom_range(0, 3) != 0);
            if (m_valid_o && m_ready_i) begin
                if (sbq.size() == 0) check("rnd_underflow", 32'(sbq.size()), 32'd1);
                else begin
                    exp_d = sbq.pop_front();
                    check("rnd_m_dat", m_dat_o, exp_d);
                end
            end
            pushed = s_valid_i && s_ready_o;
            if (pushed) begin
                sbq.push_back(s_dat_i);
                sent++;
            end
            @(posedge clk_i); #1;
            cyc++;
            check("rnd_cnt", 32'(cnt_o), 32'(sbq.size()));
        end
        if (sent < 10000) check("rnd_timeout", 32'(sent), 32'd10000);

        s_valid_i = 1'b0; m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (m_valid_o) begin
                if (sbq.size() == 0) check("drain_underflow", 32'(sbq.size()), 32'd1);
                else begin
                    exp_d = sbq.pop_front();
                    check("drain_m_dat", m_dat_o, exp_d);
                end
            end
            @(posedge clk_i); #1;
        end
        check("drain_left", 32'(sbq.size()), 32'd0);
        check("drain_cnt", 32'(cnt_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
